// File: rtl/bf2i_stage_ctrl_if.sv
// Handshake/control bundle between the BF2I stage sequencer and its neighbours.
// BF2I_STAGE_CTRL_FRMCNT_EN adds the frame_cnt signal.
interface bf2i_stage_ctrl_if #(
    parameter int HALF = 8,
    parameter int AW   = $clog2(HALF)
);
    logic          in_valid;
    logic          in_sop;
    logic          in_ready;
    logic          bf_en;
    logic          buf_we;
    logic          buf_wsel;
    logic [AW-1:0] buf_waddr;
    logic [AW-1:0] buf_raddr;
    logic          out_sel;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic          frame_err;
    logic          busy;
`ifdef BF2I_STAGE_CTRL_FRMCNT_EN
    logic [15:0]   frame_cnt;

    modport master (
        output in_valid, in_sop,
        input  in_ready, bf_en, buf_we, buf_wsel, buf_waddr, buf_raddr,
        input  out_sel, out_valid, out_sop, out_eop, frame_err, busy,
        input  frame_cnt
    );

    modport slave (
        input  in_valid, in_sop,
        output in_ready, bf_en, buf_we, buf_wsel, buf_waddr, buf_raddr,
        output out_sel, out_valid, out_sop, out_eop, frame_err, busy,
        output frame_cnt
    );
`else
    modport master (
        output in_valid, in_sop,
        input  in_ready, bf_en, buf_we, buf_wsel, buf_waddr, buf_raddr,
        input  out_sel, out_valid, out_sop, out_eop, frame_err, busy
    );

    modport slave (
        input  in_valid, in_sop,
        output in_ready, bf_en, buf_we, buf_wsel, buf_waddr, buf_raddr,
        output out_sel, out_valid, out_sop, out_eop, frame_err, busy
    );
`endif
endinterface

// File: rtl/bf2i_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: fill, butterfly, drain.
// Optional frame counter enabled by BF2I_STAGE_CTRL_FRMCNT_EN.
module bf2i_stage_ctrl #(
    parameter int HALF = 8,
    parameter int AW   = $clog2(HALF)
) (
    input logic             clk,
    input logic             rstn,
    bf2i_stage_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_BFLY  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [AW-1:0] LAST = AW'(HALF - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nx;
    logic          acc;
    logic          last;
    logic          sop_beat;
    logic          bfly_beat;
    logic          fill_we;
    logic          err_nx;
    logic          wb_we;
    logic [AW-1:0] wb_addr;

    assign bus.in_ready = (state != S_DRAIN);
    assign acc          = bus.in_valid & bus.in_ready;
    assign last         = (cnt == LAST);
    assign sop_beat     = acc & bus.in_sop;
    assign bfly_beat    = acc & ~bus.in_sop & (state == S_BFLY);
    assign bus.bf_en    = bfly_beat;
    assign bus.busy     = (state != S_IDLE);
    assign bus.buf_raddr = cnt;

    // A new frame's first word beats a pending write-back from an aborted frame
    assign fill_we       = sop_beat | (acc & (state == S_FILL));
    assign bus.buf_we    = fill_we | wb_we;
    assign bus.buf_wsel  = wb_we & ~fill_we;
    assign bus.buf_waddr = fill_we ? (sop_beat ? '0 : cnt) : wb_addr;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = 1'b0;
        unique case (1'b1)
            sop_beat: begin
                state_nx = S_FILL;
                cnt_nx   = ONE;
                err_nx   = (state != S_IDLE);
            end
            acc && !bus.in_sop && (state == S_IDLE): begin
                err_nx = 1'b1;
            end
            acc && !bus.in_sop && (state != S_IDLE): begin
                if (last) begin
                    cnt_nx   = '0;
                    state_nx = (state == S_FILL) ? S_BFLY : S_DRAIN;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            state == S_DRAIN: begin
                if (last) begin
                    cnt_nx   = '0;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            cnt           <= '0;
            wb_we         <= 1'b0;
            wb_addr       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sel   <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            wb_we         <= bfly_beat;
            wb_addr       <= bfly_beat ? cnt : '0;
            bus.out_valid <= bfly_beat | (state == S_DRAIN);
            bus.out_sel   <= (state == S_DRAIN);
            bus.out_sop   <= bfly_beat & (cnt == '0);
            bus.out_eop   <= (state == S_DRAIN) & last;
            bus.frame_err <= err_nx;
        end
    end

`ifdef BF2I_STAGE_CTRL_FRMCNT_EN
    logic [15:0] frame_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= '0;
        end else if ((state == S_DRAIN) && last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt;
`endif
endmodule
